// File: rtl/prio_encoder8_hs.sv
// Sequential 8-to-3 priority encoder: latches rising edges of req_i into a
// pending set and hands out the highest pending index over a valid/ready handshake.
module prio_encoder8_hs #(
    parameter logic [2:0] RESET_CODE = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req_i,
    input  logic       ready_i,
    input  logic       clr_ovr_i,
    output logic       valid_o,
    output logic [2:0] code_o,
    output logic [7:0] pending_o,
    output logic       overrun_o
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;

    logic [7:0] rise;
    logic       accept;
    logic [7:0] clr_mask;

    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign rise     = req_i & ~req_q;
    assign accept   = valid_q & ready_i;
    assign clr_mask = accept ? (8'd1 << code_q) : 8'd0;

    // A rise on a bit being cleared this cycle re-arms it without counting as an overrun.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | rise;
        overrun_d = overrun_q;
        if (clr_ovr_i) overrun_d = 1'b0;
        if (|(rise & pending_q & ~clr_mask)) overrun_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                code_d  = RESET_CODE;
                if (en && (|pending_q)) begin
                    valid_d = 1'b1;
                    code_d  = top_index(pending_q);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    code_d  = RESET_CODE;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                code_d  = RESET_CODE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 8'd0;
            pending_q <= 8'd0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= RESET_CODE;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
        end
    end

    assign valid_o   = valid_q;
    assign code_o    = code_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_prio_encoder8_hs.sv
// Directed bench for prio_encoder8_hs: a per-cycle vector table plus a
// hand-written reset-during-present sequence.
module tb_prio_encoder8_hs;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req_i;
    logic       ready_i;
    logic       clr_ovr_i;
    logic       valid_o;
    logic [2:0] code_o;
    logic [7:0] pending_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;

    prio_encoder8_hs #(.RESET_CODE(3'b000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_i     (req_i),
        .ready_i   (ready_i),
        .clr_ovr_i (clr_ovr_i),
        .valid_o   (valid_o),
        .code_o    (code_o),
        .pending_o (pending_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] c;
        logic [7:0] p;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [7:0] r, input logic rd, input logic cl,
                       input logic v, input logic [2:0] c, input logic [7:0] p, input logic o);
        vec_t t;
        t.en = e; t.req = r; t.rdy = rd; t.clr = cl;
        t.v = v; t.c = c; t.p = p; t.o = o;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic o);
        chk("valid_o",   idx, {7'd0, valid_o},   {7'd0, v});
        chk("code_o",    idx, {5'd0, code_o},    {5'd0, c});
        chk("pending_o", idx, pending_o,         p);
        chk("overrun_o", idx, {7'd0, overrun_o}, {7'd0, o});
    endtask

    task automatic drive(input logic e, input logic [7:0] r, input logic rd, input logic cl);
        en = e; req_i = r; ready_i = rd; clr_ovr_i = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: inputs applied for one cycle, outputs expected after that edge.
        //   en  req    rdy clr   v  c     p      o
        // single pulse on bit 5
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        add(1, 8'h20, 1, 0,   0, 3'd0, 8'h20, 0);
        add(1, 8'h00, 1, 0,   1, 3'd5, 8'h20, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // bits 7 and 0 together: 7 first, one-cycle gap, then 0
        add(1, 8'h81, 1, 0,   0, 3'd0, 8'h81, 0);
        add(1, 8'h00, 1, 0,   1, 3'd7, 8'h81, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h01, 0);
        add(1, 8'h00, 1, 0,   1, 3'd0, 8'h01, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // bit 3 held under backpressure while bit 6 arrives; en toggled mid-present
        add(1, 8'h08, 0, 0,   0, 3'd0, 8'h08, 0);
        add(1, 8'h08, 0, 0,   1, 3'd3, 8'h08, 0);
        add(1, 8'h48, 0, 0,   1, 3'd3, 8'h48, 0);
        add(0, 8'h48, 0, 0,   1, 3'd3, 8'h48, 0);
        add(1, 8'h00, 0, 0,   1, 3'd3, 8'h48, 0);
        add(0, 8'h00, 0, 0,   1, 3'd3, 8'h48, 0);
        add(1, 8'h00, 0, 0,   1, 3'd3, 8'h48, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h40, 0);
        add(1, 8'h00, 1, 0,   1, 3'd6, 8'h40, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // en low: accumulate without launching
        add(0, 8'h14, 1, 0,   0, 3'd0, 8'h14, 0);
        add(0, 8'h14, 1, 0,   0, 3'd0, 8'h14, 0);
        add(0, 8'h00, 1, 0,   0, 3'd0, 8'h14, 0);
        add(1, 8'h00, 1, 0,   1, 3'd4, 8'h14, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h04, 0);
        add(1, 8'h00, 1, 0,   1, 3'd2, 8'h04, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // overrun on bit 1, sticky until cleared
        add(1, 8'h02, 0, 0,   0, 3'd0, 8'h02, 0);
        add(1, 8'h00, 0, 0,   1, 3'd1, 8'h02, 0);
        add(1, 8'h02, 0, 0,   1, 3'd1, 8'h02, 1);
        add(1, 8'h00, 0, 0,   1, 3'd1, 8'h02, 1);
        add(1, 8'h00, 0, 1,   1, 3'd1, 8'h02, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // rise coincident with accept of the same bit: stays pending, no overrun
        add(1, 8'h02, 0, 0,   0, 3'd0, 8'h02, 0);
        add(1, 8'h00, 0, 0,   1, 3'd1, 8'h02, 0);
        add(1, 8'h02, 1, 0,   0, 3'd0, 8'h02, 0);
        add(1, 8'h00, 1, 0,   1, 3'd1, 8'h02, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);
        // overrun set and clear in the same cycle: set wins
        add(1, 8'h02, 0, 0,   0, 3'd0, 8'h02, 0);
        add(1, 8'h00, 0, 0,   1, 3'd1, 8'h02, 0);
        add(1, 8'h02, 0, 1,   1, 3'd1, 8'h02, 1);
        add(1, 8'h00, 0, 1,   1, 3'd1, 8'h02, 0);
        add(1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 0);

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].req, vecs[i].rdy, vecs[i].clr);
            tick();
            chk_all(i, vecs[i].v, vecs[i].c, vecs[i].p, vecs[i].o);
        end

        // Reset mid-present with req_i[0] held high across the release.
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        chk_all(100, 1'b0, 3'd0, 8'h01, 1'b0);
        tick();
        chk_all(101, 1'b1, 3'd0, 8'h01, 1'b0);
        drive(1'b1, 8'h81, 1'b0, 1'b0);
        tick();
        chk_all(102, 1'b1, 3'd0, 8'h81, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_all(103, 1'b0, 3'd0, 8'h00, 1'b0);
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        tick();
        chk_all(104, 1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all(105, 1'b0, 3'd0, 8'h01, 1'b0);
        tick();
        chk_all(106, 1'b1, 3'd0, 8'h01, 1'b0);
        tick();
        chk_all(107, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all(108 + k, 1'b0, 3'd0, 8'h00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
